// File: rtl/writeback_retire_queue_pkg.sv
// ---------------------------------------------------------------------------
// writeback_retire_queue_pkg
// Shared definitions for the writeback retire queue:
//   - load funct3 encodings (RVGA_LB/LH/LW/LBU/LHU)
//   - width of the raw memory word delivered with a load
//   - a helper that flags funct3 codes that are not legal loads
// No ports (package).
// ---------------------------------------------------------------------------
package writeback_retire_queue_pkg;

  localparam int RVGA_LD_DATA_W = 32;

  typedef enum logic [2:0] {
    RVGA_LB  = 3'b000,
    RVGA_LH  = 3'b001,
    RVGA_LW  = 3'b010,
    RVGA_LBU = 3'b100,
    RVGA_LHU = 3'b101
  } rvga_ld_funct3_e;

  // 011, 110 and 111 are not load encodings.
  function automatic logic rvga_ld_illegal(input logic [2:0] funct3);
    return (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
  endfunction

endpackage

// File: rtl/writeback_retire_queue_if.sv
// ---------------------------------------------------------------------------
// writeback_retire_queue_if
// Memory-stage -> writeback handshake bundle. Signal names keep the
// queue's point of view (_i into the queue, _o out of it).
//   v_i / ready_o   valid/ready; op taken when both are high
//   pc_i            op pc
//   rd_i, rd_w_v_i  destination register and its write enable
//   br_v_i, br_tgt_i taken branch/jump and its target
//   alu_result_i    result, or load address when ld_v_i
//   ld_v_i, funct3_i, ld_data_i  load flag, size/sign code, raw word
// Modports: master = memory stage, slave = retire queue.
// ---------------------------------------------------------------------------
interface writeback_retire_queue_if
  import writeback_retire_queue_pkg::*;
#(
  parameter int WORD_W_P = 32,
  parameter int REG_W_P  = 5
);
  logic                      v_i;
  logic                      ready_o;
  logic [WORD_W_P-1:0]       pc_i;
  logic [REG_W_P-1:0]        rd_i;
  logic                      rd_w_v_i;
  logic                      br_v_i;
  logic [WORD_W_P-1:0]       br_tgt_i;
  logic [WORD_W_P-1:0]       alu_result_i;
  logic                      ld_v_i;
  logic [2:0]                funct3_i;
  logic [RVGA_LD_DATA_W-1:0] ld_data_i;

  modport master (
    output v_i, pc_i, rd_i, rd_w_v_i, br_v_i, br_tgt_i,
           alu_result_i, ld_v_i, funct3_i, ld_data_i,
    input  ready_o
  );

  modport slave (
    input  v_i, pc_i, rd_i, rd_w_v_i, br_v_i, br_tgt_i,
           alu_result_i, ld_v_i, funct3_i, ld_data_i,
    output ready_o
  );
endinterface

// File: rtl/writeback_load_align.sv
// ---------------------------------------------------------------------------
// writeback_load_align
// Combinational load extraction: picks the byte/half/word lane addressed by
// addr_i out of the raw memory word and sign- or zero-extends it.
//   ld_data_i  in  32        raw aligned memory word
//   addr_i     in  2         low address bits (byte lane)
//   funct3_i   in  3         load size/sign code
//   data_o     out WORD_W_P  extended load value
//   err_o      out 1         misaligned access or illegal funct3
// ---------------------------------------------------------------------------
module writeback_load_align
  import writeback_retire_queue_pkg::*;
#(
  parameter int WORD_W_P = 32
) (
  input  logic [RVGA_LD_DATA_W-1:0] ld_data_i,
  input  logic [1:0]                addr_i,
  input  logic [2:0]                funct3_i,
  output logic [WORD_W_P-1:0]       data_o,
  output logic                      err_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = ld_data_i[7:0];
    case (addr_i)
      2'd1:    byte_sel = ld_data_i[15:8];
      2'd2:    byte_sel = ld_data_i[23:16];
      2'd3:    byte_sel = ld_data_i[31:24];
      default: byte_sel = ld_data_i[7:0];
    endcase
    // addr_i[0] set on a half access is flagged as an error, so only addr_i[1] selects.
    half_sel = addr_i[1] ? ld_data_i[31:16] : ld_data_i[15:0];

    data_o = '0;
    err_o  = 1'b0;
    case (funct3_i)
      RVGA_LB:  data_o = WORD_W_P'($signed(byte_sel));
      RVGA_LBU: data_o = WORD_W_P'(byte_sel);
      RVGA_LH: begin
        data_o = WORD_W_P'($signed(half_sel));
        err_o  = addr_i[0];
      end
      RVGA_LHU: begin
        data_o = WORD_W_P'(half_sel);
        err_o  = addr_i[0];
      end
      RVGA_LW: begin
        data_o = WORD_W_P'($signed(ld_data_i));
        err_o  = (addr_i != 2'd0);
      end
      default: err_o = rvga_ld_illegal(funct3_i);
    endcase
  end

endmodule

// File: rtl/writeback_retire_queue.sv
// ---------------------------------------------------------------------------
// writeback_retire_queue
// In-order DEPTH_P-entry writeback queue. Load data is aligned/extended when
// an op is accepted; at most one op retires per cycle into registered
// register-file and redirect outputs. Retiring a taken branch flushes the
// rest of the queue (and any same-cycle enqueue).
//   clk_i, rst_i    clock, synchronous active-high reset
//   stall_v_i       hold the head; no retire this cycle
//   mem_if          slave side of the memory-stage handshake bundle
//   rd_o, rd_data_o, rd_w_v_o   retired register write
//   br_v_o, br_tgt_o            redirect strobe and target
//   pc_o                        retired pc
//   ld_err_v_o                  retired load was misaligned/illegal
//   retire_cnt_o                retired-op counter (wraps)
//   count_o                     current occupancy
// ---------------------------------------------------------------------------
module writeback_retire_queue
  import writeback_retire_queue_pkg::*;
#(
  parameter int WORD_W_P = 32,
  parameter int REG_W_P  = 5,
  parameter int DEPTH_P  = 4,
  parameter int CNT_W_P  = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         stall_v_i,
  writeback_retire_queue_if.slave      mem_if,
  output logic [REG_W_P-1:0]           rd_o,
  output logic [WORD_W_P-1:0]          rd_data_o,
  output logic                         rd_w_v_o,
  output logic                         br_v_o,
  output logic [WORD_W_P-1:0]          br_tgt_o,
  output logic [WORD_W_P-1:0]          pc_o,
  output logic                         ld_err_v_o,
  output logic [CNT_W_P-1:0]           retire_cnt_o,
  output logic [$clog2(DEPTH_P+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH_P);
  localparam int OCC_W = $clog2(DEPTH_P+1);

  typedef struct packed {
    logic [WORD_W_P-1:0] pc;
    logic [REG_W_P-1:0]  rd;
    logic                rd_w_v;
    logic                br_v;
    logic [WORD_W_P-1:0] br_tgt;
    logic [WORD_W_P-1:0] data;
    logic                err;
  } rvga_writeback_entry_t;

  // Pointers wrap modulo DEPTH_P, which need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH_P-1)) ? '0 : ptr + 1'b1;
  endfunction

  rvga_writeback_entry_t mem_q [DEPTH_P];
  rvga_writeback_entry_t mem_d [DEPTH_P];
  rvga_writeback_entry_t head;
  rvga_writeback_entry_t new_entry;

  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0]    count_q, count_d;
  logic [REG_W_P-1:0]  rd_q, rd_d;
  logic [WORD_W_P-1:0] rd_data_q, rd_data_d;
  logic [WORD_W_P-1:0] br_tgt_q, br_tgt_d;
  logic [WORD_W_P-1:0] pc_q, pc_d;
  logic                rd_w_v_q, rd_w_v_d;
  logic                br_v_q, br_v_d;
  logic                ld_err_v_q, ld_err_v_d;
  logic [CNT_W_P-1:0]  retire_cnt_q, retire_cnt_d;

  logic                ready, retire, flush, enq;
  logic [WORD_W_P-1:0] ld_word;
  logic                ld_err;

  writeback_load_align #(.WORD_W_P(WORD_W_P)) u_load_align (
    .ld_data_i (mem_if.ld_data_i),
    .addr_i    (mem_if.alu_result_i[1:0]),
    .funct3_i  (mem_if.funct3_i),
    .data_o    (ld_word),
    .err_o     (ld_err)
  );

  // Depends only on the occupancy register: no path from v_i or stall_v_i.
  assign ready          = (count_q != OCC_W'(DEPTH_P));
  assign mem_if.ready_o = ready;

  always_comb begin
    head   = mem_q[rd_ptr_q];
    retire = (count_q != '0) && !stall_v_i;
    flush  = retire && head.br_v;
    // An op offered while a branch retires is dropped with the rest of the queue.
    enq    = mem_if.v_i && ready && !flush;

    new_entry.pc     = mem_if.pc_i;
    new_entry.rd     = mem_if.rd_i;
    new_entry.rd_w_v = mem_if.rd_w_v_i;
    new_entry.br_v   = mem_if.br_v_i;
    new_entry.br_tgt = mem_if.br_tgt_i;
    new_entry.data   = mem_if.ld_v_i ? ld_word : mem_if.alu_result_i;
    new_entry.err    = mem_if.ld_v_i & ld_err;

    mem_d = mem_q;
    if (enq) mem_d[wr_ptr_q] = new_entry;

    wr_ptr_d = enq    ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = retire ? next_ptr(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + OCC_W'(enq) - OCC_W'(retire);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end

    rd_d         = rd_q;
    rd_data_d    = rd_data_q;
    br_tgt_d     = br_tgt_q;
    pc_d         = pc_q;
    retire_cnt_d = retire_cnt_q;
    rd_w_v_d     = 1'b0;
    br_v_d       = 1'b0;
    ld_err_v_d   = 1'b0;
    if (retire) begin
      rd_d         = head.rd;
      rd_data_d    = head.data;
      br_tgt_d     = head.br_tgt;
      pc_d         = head.pc;
      rd_w_v_d     = head.rd_w_v && !head.err && (head.rd != '0);
      br_v_d       = head.br_v;
      ld_err_v_d   = head.err;
      retire_cnt_d = retire_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      rd_q         <= '0;
      rd_data_q    <= '0;
      br_tgt_q     <= '0;
      pc_q         <= '0;
      rd_w_v_q     <= 1'b0;
      br_v_q       <= 1'b0;
      ld_err_v_q   <= 1'b0;
      retire_cnt_q <= '0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      rd_q         <= rd_d;
      rd_data_q    <= rd_data_d;
      br_tgt_q     <= br_tgt_d;
      pc_q         <= pc_d;
      rd_w_v_q     <= rd_w_v_d;
      br_v_q       <= br_v_d;
      ld_err_v_q   <= ld_err_v_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // Entry storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign rd_o         = rd_q;
  assign rd_data_o    = rd_data_q;
  assign rd_w_v_o     = rd_w_v_q;
  assign br_v_o       = br_v_q;
  assign br_tgt_o     = br_tgt_q;
  assign pc_o         = pc_q;
  assign ld_err_v_o   = ld_err_v_q;
  assign retire_cnt_o = retire_cnt_q;
  assign count_o      = count_q;

endmodule

// File: tb/tb_writeback_retire_queue.sv
module tb_writeback_retire_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic [4:0]  rd_o;
  logic [31:0] rd_data_o, br_tgt_o, pc_o, retire_cnt_o;
  logic        rd_w_v_o, br_v_o, ld_err_v_o;
  logic [2:0]  count_o;

  always #5 clk = ~clk;

  writeback_retire_queue_if #(.WORD_W_P(32), .REG_W_P(5)) bus ();

  writeback_retire_queue #(
    .WORD_W_P(32), .REG_W_P(5), .DEPTH_P(DEPTH), .CNT_W_P(32)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .stall_v_i    (stall),
    .mem_if       (bus),
    .rd_o         (rd_o),
    .rd_data_o    (rd_data_o),
    .rd_w_v_o     (rd_w_v_o),
    .br_v_o       (br_v_o),
    .br_tgt_o     (br_tgt_o),
    .pc_o         (pc_o),
    .ld_err_v_o   (ld_err_v_o),
    .retire_cnt_o (retire_cnt_o),
    .count_o      (count_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model: a queue of retired-op records -------
  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    bit          wv;
    bit          br;
    logic [31:0] tgt;
    logic [31:0] data;
    bit          err;
  } ment_t;

  ment_t       mq[$];
  ment_t       m_head, m_new;
  bit          live = 0;
  bit          data_known = 1;
  bit          m_ready, m_retire, m_flush;
  logic [31:0] e_pc = 0, e_tgt = 0, e_data = 0, e_cnt = 0;
  logic [4:0]  e_rd = 0;
  bit          e_wv = 0, e_br = 0, e_err = 0;

  function automatic void m_extract(input logic [31:0] w, input logic [1:0] a,
                                    input logic [2:0] f, output logic [31:0] d,
                                    output bit e);
    logic [31:0] sh;
    byte         sb;
    shortint     sw;
    int          t;
    sh = w >> (8 * a);
    sb = byte'(sh[7:0]);
    sw = shortint'(sh[15:0]);
    d  = w;
    e  = 0;
    case (f)
      3'd0: begin t = int'(sb); d = 32'(t); end
      3'd1: begin t = int'(sw); d = 32'(t); e = (a % 2) != 0; end
      3'd2: begin d = w; e = (a != 0); end
      3'd4: d = sh & 32'h0000_00FF;
      3'd5: begin d = sh & 32'h0000_FFFF; e = (a % 2) != 0; end
      default: e = 1;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      e_pc = 0; e_tgt = 0; e_data = 0; e_cnt = 0; e_rd = 0;
      e_wv = 0; e_br = 0; e_err = 0;
      data_known = 1;
      live = 1;
    end else if (live) begin
      m_ready  = (mq.size() != DEPTH);
      m_retire = (mq.size() != 0) && !stall;
      m_flush  = 0;
      e_wv = 0; e_br = 0; e_err = 0;
      if (m_retire) begin
        m_head = mq.pop_front();
        e_wv   = m_head.wv && !m_head.err && (m_head.rd != 0);
        e_br   = m_head.br;
        e_err  = m_head.err;
        e_rd   = m_head.rd;
        e_pc   = m_head.pc;
        e_tgt  = m_head.tgt;
        e_data = m_head.data;
        data_known = !m_head.err;
        e_cnt  = e_cnt + 1;
        if (m_head.br) begin
          mq.delete();
          m_flush = 1;
        end
      end
      if (bus.v_i && m_ready && !m_flush) begin
        m_new.pc  = bus.pc_i;
        m_new.rd  = bus.rd_i;
        m_new.wv  = bus.rd_w_v_i;
        m_new.br  = bus.br_v_i;
        m_new.tgt = bus.br_tgt_i;
        if (bus.ld_v_i)
          m_extract(bus.ld_data_i, bus.alu_result_i[1:0], bus.funct3_i, m_new.data, m_new.err);
        else begin
          m_new.data = bus.alu_result_i;
          m_new.err  = 0;
        end
        mq.push_back(m_new);
      end
    end
    #1;
    if (live) begin
      chk("m_count",  64'(count_o), 64'(mq.size()));
      chk("m_ready",  64'(bus.ready_o), 64'(mq.size() != DEPTH));
      chk("m_rd_w_v", 64'(rd_w_v_o), 64'(e_wv));
      chk("m_br_v",   64'(br_v_o), 64'(e_br));
      chk("m_ld_err", 64'(ld_err_v_o), 64'(e_err));
      chk("m_rd",     64'(rd_o), 64'(e_rd));
      chk("m_pc",     64'(pc_o), 64'(e_pc));
      chk("m_br_tgt", 64'(br_tgt_o), 64'(e_tgt));
      chk("m_cnt",    64'(retire_cnt_o), 64'(e_cnt));
      if (data_known) chk("m_rd_data", 64'(rd_data_o), 64'(e_data));
    end
  end

  // ---------------- stimulus ---------------------------------------------
  task automatic put_op(input logic [31:0] pc, input logic [4:0] rd, input bit wv,
                        input bit br, input logic [31:0] tgt, input logic [31:0] alu,
                        input bit ldv, input logic [2:0] f3, input logic [31:0] ldd);
    bus.v_i          = 1'b1;
    bus.pc_i         = pc;
    bus.rd_i         = rd;
    bus.rd_w_v_i     = wv;
    bus.br_v_i       = br;
    bus.br_tgt_i     = tgt;
    bus.alu_result_i = alu;
    bus.ld_v_i       = ldv;
    bus.funct3_i     = f3;
    bus.ld_data_i    = ldd;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // One op with no stall: accepted at the first edge, retired at the second.
  task automatic single_op(input logic [31:0] pc, input logic [4:0] rd, input bit wv,
                           input logic [31:0] alu, input bit ldv, input logic [2:0] f3);
    put_op(pc, rd, wv, 1'b0, 32'h0, alu, ldv, f3, 32'h8000_F0A5);
    step();
    bus.v_i = 1'b0;
    step();
  endtask

  initial begin
    put_op(0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.v_i = 1'b0;
    rst = 1'b1;
    stall = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Load extraction on 32'h8000_F0A5
    single_op(32'h100, 5'd1, 1'b1, 32'h1000, 1'b1, 3'b000);
    chk("lb_data", 64'(rd_data_o), 64'h0000_0000_FFFF_FFA5);
    chk("lb_wv",   64'(rd_w_v_o), 64'd1);
    single_op(32'h104, 5'd2, 1'b1, 32'h1003, 1'b1, 3'b100);
    chk("lbu_data", 64'(rd_data_o), 64'h0000_0080);
    single_op(32'h108, 5'd3, 1'b1, 32'h1002, 1'b1, 3'b001);
    chk("lh_data", 64'(rd_data_o), 64'h0000_0000_FFFF_8000);
    single_op(32'h10C, 5'd4, 1'b1, 32'h1002, 1'b1, 3'b010);
    chk("lw_mis_wv",  64'(rd_w_v_o), 64'd0);
    chk("lw_mis_err", 64'(ld_err_v_o), 64'd1);

    // x0 suppression
    single_op(32'h110, 5'd0, 1'b1, 32'd5, 1'b0, 3'b000);
    chk("x0_wv",  64'(rd_w_v_o), 64'd0);
    chk("x0_cnt", 64'(retire_cnt_o), 64'd5);

    // Backpressure: 5 ops under stall, 5th held at v_i
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      put_op(32'h200 + 32'(4 * i), 5'(i + 1), 1'b1, 1'b0, 32'h0, 32'(i), 1'b0, 3'b0, 32'h0);
      step();
    end
    chk("bp_ready", 64'(bus.ready_o), 64'd0);
    chk("bp_count", 64'(count_o), 64'd4);
    stall = 1'b0;
    step();
    chk("bp_pc0",    64'(pc_o), 64'h200);
    chk("bp_ready1", 64'(bus.ready_o), 64'd1);
    step();
    chk("bp_pc1", 64'(pc_o), 64'h204);
    bus.v_i = 1'b0;
    for (int i = 2; i < 5; i++) begin
      step();
      chk("bp_pc_n", 64'(pc_o), 64'(32'h200 + 32'(4 * i)));
      chk("bp_wv_n", 64'(rd_w_v_o), 64'd1);
    end

    // Branch flush: {br, A, B} queued, C offered while br retires
    stall = 1'b1;
    put_op(32'h300, 5'd3, 1'b1, 1'b1, 32'h8000, 32'h304, 1'b0, 3'b0, 32'h0);
    step();
    put_op(32'h304, 5'd4, 1'b1, 1'b0, 32'h0, 32'hA, 1'b0, 3'b0, 32'h0);
    step();
    put_op(32'h308, 5'd5, 1'b1, 1'b0, 32'h0, 32'hB, 1'b0, 3'b0, 32'h0);
    step();
    put_op(32'h30C, 5'd6, 1'b1, 1'b0, 32'h0, 32'hC, 1'b0, 3'b0, 32'h0);
    stall = 1'b0;
    step();
    chk("fl_br_v",  64'(br_v_o), 64'd1);
    chk("fl_tgt",   64'(br_tgt_o), 64'h8000);
    chk("fl_pc",    64'(pc_o), 64'h300);
    chk("fl_count", 64'(count_o), 64'd0);
    bus.v_i = 1'b0;
    step();
    chk("fl_br_v_off", 64'(br_v_o), 64'd0);
    chk("fl_wv_off",   64'(rd_w_v_o), 64'd0);
    step();
    chk("fl_cnt", 64'(retire_cnt_o), 64'd11);
    chk("fl_pc_hold", 64'(pc_o), 64'h300);

    // Reset mid-operation
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      put_op(32'h500 + 32'(4 * i), 5'd7, 1'b1, 1'b0, 32'h0, 32'h77, 1'b0, 3'b0, 32'h0);
      step();
    end
    bus.v_i = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    stall = 1'b0;
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_ready", 64'(bus.ready_o), 64'd1);
    chk("rst_cnt",   64'(retire_cnt_o), 64'd0);
    chk("rst_strb",  64'({rd_w_v_o, br_v_o, ld_err_v_o}), 64'd0);
    chk("rst_data",  64'(rd_data_o), 64'd0);

    // Wrap: 2*DEPTH+1 ops back to back
    for (int i = 0; i < 2 * DEPTH + 1; i++) begin
      put_op(32'h400 + 32'(4 * i), 5'(i + 1), 1'b1, 1'b0, 32'h0, 32'h900 + 32'(i), 1'b0, 3'b0, 32'h0);
      step();
      if (i >= 1) begin
        chk("wr_pc",    64'(pc_o), 64'(32'h400 + 32'(4 * (i - 1))));
        chk("wr_data",  64'(rd_data_o), 64'(32'h900 + 32'(i - 1)));
        chk("wr_count", 64'(count_o), 64'd1);
      end
    end
    bus.v_i = 1'b0;
    step();
    chk("wr_pc_last", 64'(pc_o), 64'h420);
    chk("wr_cnt",     64'(retire_cnt_o), 64'd9);

    // Randomized traffic checked by the model each cycle
    for (int c = 0; c < 600; c++) begin
      put_op($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 9) == 0), $urandom, $urandom,
             1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom);
      bus.v_i = ($urandom_range(0, 3) != 0);
      stall   = ($urandom_range(0, 3) == 0);
      rst     = ($urandom_range(0, 63) == 0);
      step();
    end
    rst = 1'b0;
    bus.v_i = 1'b0;
    stall = 1'b0;
    repeat (DEPTH + 2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
